// File: rtl/bellek_hakem_pkg.sv
// Shared definitions for the memory access controller: state encoding,
// default widths and the main memory base address.
package bellek_hakem_pkg;

  localparam int ADRES_BIT_VARS = 32;
  localparam int VERI_BIT_VARS  = 32;
  localparam int SAYAC_BIT      = 4;

  localparam logic [31:0] BELLEK_ADRES = 32'h8000_0000;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    BEKLE = 2'd1,
    ERIS  = 2'd2,
    TAMAM = 2'd3
  } durum_t;

endpackage

// File: rtl/bellek_hakem_rr.sv
// Two-input round-robin arbiter; the last-grant flop decides ties.
module hakem_rr (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_istek,
  input  logic       i_kabul,
  output logic       o_secim
);

  // Reset as "port 1 served last" so port 0 wins the first tie.
  logic r_son;

  assign o_secim = (i_istek == 2'b11) ? ~r_son : i_istek[1];

  always_ff @(posedge i_clk) begin
    if (i_rst)        r_son <= 1'b1;
    else if (i_kabul) r_son <= o_secim;
  end

endmodule

// File: rtl/bellek_hakem.sv
// Memory access controller: round-robin between the processor (port 0) and a
// secondary master (port 1), each access stretched by GECIKME wait cycles.
module bellek_hakem
  import bellek_hakem_pkg::*;
#(
  parameter int ADRES_BIT = ADRES_BIT_VARS,
  parameter int VERI_BIT  = VERI_BIT_VARS,
  parameter int GECIKME   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_p0_istek,
  input  logic                 i_p0_yaz,
  input  logic [ADRES_BIT-1:0] i_p0_adres,
  input  logic [VERI_BIT-1:0]  i_p0_yaz_veri,
  output logic [VERI_BIT-1:0]  o_p0_oku_veri,
  output logic                 o_p0_hazir,
  input  logic                 i_p1_istek,
  input  logic                 i_p1_yaz,
  input  logic [ADRES_BIT-1:0] i_p1_adres,
  input  logic [VERI_BIT-1:0]  i_p1_yaz_veri,
  output logic [VERI_BIT-1:0]  o_p1_oku_veri,
  output logic                 o_p1_hazir,
  output logic [ADRES_BIT-1:0] o_bellek_adres,
  output logic [VERI_BIT-1:0]  o_bellek_yaz_veri,
  output logic                 o_bellek_yaz,
  input  logic [VERI_BIT-1:0]  i_bellek_oku_veri
);

  if (GECIKME < 0 || GECIKME > 15) begin : g_param_hata
    $error("bellek_hakem: GECIKME must be in 0..15");
  end

  localparam logic [SAYAC_BIT-1:0] SAYAC_YUK =
    (GECIKME > 0) ? SAYAC_BIT'(GECIKME - 1) : '0;

  durum_t                        r_durum, w_sonraki;
  logic [SAYAC_BIT-1:0]          r_sayac;
  logic                          r_yaz, r_id;
  logic [ADRES_BIT-1:0]          r_adres;
  logic [VERI_BIT-1:0]           r_yaz_veri, r_oku_veri;

  logic [1:0]                    w_istek, w_yaz_p, w_hazir;
  logic [1:0][ADRES_BIT-1:0]     w_adres_p;
  logic [1:0][VERI_BIT-1:0]      w_veri_p;
  logic                          w_secim, w_kabul;

  assign w_istek   = {i_p1_istek, i_p0_istek};
  assign w_yaz_p   = {i_p1_yaz, i_p0_yaz};
  assign w_adres_p = {i_p1_adres, i_p0_adres};
  assign w_veri_p  = {i_p1_yaz_veri, i_p0_yaz_veri};

  hakem_rr u_hakem (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_istek (w_istek),
    .i_kabul (w_kabul),
    .o_secim (w_secim)
  );

  always_comb begin
    w_sonraki = r_durum;
    w_kabul   = 1'b0;
    case (r_durum)
      BOSTA: if (|w_istek) begin
        w_kabul   = 1'b1;
        w_sonraki = (GECIKME > 0) ? BEKLE : ERIS;
      end
      BEKLE:   if (r_sayac == '0) w_sonraki = ERIS;
      ERIS:    w_sonraki = TAMAM;
      TAMAM:   w_sonraki = BOSTA;
      default: w_sonraki = BOSTA;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_durum    <= BOSTA;
      r_sayac    <= '0;
      r_yaz      <= 1'b0;
      r_id       <= 1'b0;
      r_adres    <= '0;
      r_yaz_veri <= '0;
      r_oku_veri <= '0;
    end else begin
      r_durum <= w_sonraki;
      if (w_kabul) begin
        r_id       <= w_secim;
        r_yaz      <= w_yaz_p[w_secim];
        r_adres    <= w_adres_p[w_secim];
        r_yaz_veri <= w_veri_p[w_secim];
        r_sayac    <= SAYAC_YUK;
      end else if (r_durum == BEKLE && r_sayac != '0) begin
        r_sayac <= r_sayac - 1'b1;
      end
      // Writes leave the read register untouched.
      if (r_durum == ERIS && !r_yaz) r_oku_veri <= i_bellek_oku_veri;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_port
    assign w_hazir[g] = (r_durum == TAMAM) && (r_id == 1'(g));
  end

  assign o_p0_hazir        = w_hazir[0];
  assign o_p1_hazir        = w_hazir[1];
  assign o_p0_oku_veri     = r_oku_veri;
  assign o_p1_oku_veri     = r_oku_veri;
  assign o_bellek_adres    = r_adres & ~(ADRES_BIT'(3));
  assign o_bellek_yaz_veri = r_yaz_veri;
  assign o_bellek_yaz      = (r_durum == ERIS) && r_yaz;

endmodule
